mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Sequences a single-port unified memory shared between the processor's instruction-fetch stage and its load/store stage. It accepts one access at a time, issues it to memory, waits a fixed latency, returns read data, and generates per-requester stall signals that freeze the datapath until the access completes. It sits between the fetch/memory stages and the memory model, and it also gates fetch once the processor halts.

## Interface
- MEM_LAT, 2: memory read latency in cycles from the mem_en cycle to valid mem_rdata; legal range 1..15.
- AW, 16: address width.
- DW, 16: data width.

- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held until if_done.
- if_addr  in  AW  fetch address.
- if_rdata  out  DW  fetched instruction; valid while if_done=1.
- if_done  out  1  one-cycle fetch completion pulse.
- if_stall  out  1  if_req & ~if_done.
- d_rd  in  1  load request; held until d_done.
- d_wr  in  1  store request; held until d_done.
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_rdata  out  DW  load data; valid while d_done=1.
- d_done  out  1  one-cycle data completion pulse.
- d_stall  out  1  (d_rd|d_wr) & ~d_done.
- halt  in  1  processor halt.
- mem_en  out  1  memory access strobe, one cycle per access.
- mem_wr  out  1  write qualifier for mem_en.
- mem_addr  out  AW  registered address.
- mem_wdata  out  DW  registered write data.
- mem_rdata  in  DW  memory read data.
- if_grants  out  16  count of completed fetches, saturating at 0xFFFF.
- d_grants  out  16  count of completed data accesses, saturating at 0xFFFF.

## Operation
- States: IDLE, ISSUE, WAIT, DONE, HALTED.
- IDLE: samples requests at the clock edge. Priority order:
  - halt=1: go to HALTED and grant nothing.
  - d_rd|d_wr: grant data.
  - if_req: grant fetch.
  - otherwise: stay in IDLE.
- Data beats fetch because the data access belongs to the older instruction. Priority is fixed.
- d_rd and d_wr both set: treated as a store.
- On grant: latch owner, mem_addr, mem_wdata and mem_wr; go to ISSUE.
- ISSUE: mem_en=1 for exactly one cycle; load cnt=MEM_LAT; go to WAIT.
- WAIT: cnt decrements each cycle. When cnt reaches 1, capture mem_rdata into the owner's rdata register and go to DONE.
  - Stores also wait the full MEM_LAT.
  - Stores do not change d_rdata.
- DONE: owner's done=1 for one cycle. The owner's grant counter increments (saturating). Requests are ignored in DONE. Next state is IDLE.
- halt rising during ISSUE/WAIT/DONE: the in-flight access completes normally, then IDLE moves to HALTED.
- HALTED: no grants; if_stall/d_stall follow their requests; exits only via rst.
- mem_en, mem_wr, mem_addr, mem_wdata are 0 outside ISSUE.
- rdata registers hold their last captured value.

## Timing
- Reset value of every output: 0; state IDLE; cnt 0. Reset takes effect asynchronously, mid-access included, and the access is dropped.
- Request sampled in IDLE at edge T:
  - mem_en high in cycle T+1.
  - mem_rdata sampled at the end of cycle T+1+MEM_LAT.
  - done high in cycle T+2+MEM_LAT.
  - Earliest next sample at the edge ending cycle T+3+MEM_LAT.
- Back-to-back accesses: one every MEM_LAT+3 cycles.
- Stalls are combinational from requests and done; no registered delay.
- Requester contract: address, data and request stay stable from assertion through the done cycle. Deassertion before done is illegal; the access still completes.

## Test plan
- Fetch only, MEM_LAT=2: if_req=1, if_addr=0x0010, memory returns 0xC123 → mem_en one cycle after sample; if_done 4 cycles after sample with if_rdata=0xC123; if_stall high for the 4 prior cycles; if_grants=1.
- Simultaneous: if_req=1 at 0x0000 and d_rd=1 at 0x0100 in the same IDLE cycle → data served first (d_done, d_rdata=mem[0x0100]); fetch issued at the next IDLE sample; if_stall stays high through both accesses.
- Store: d_wr=1, d_addr=0x0200, d_wdata=0xBEEF → exactly one mem_en with mem_wr=1, mem_addr=0x0200, mem_wdata=0xBEEF; d_done after MEM_LAT+2 cycles; d_rdata unchanged.
- Halt during WAIT of a fetch → fetch completes with if_done; arbiter enters HALTED; a subsequent if_req never produces mem_en and if_stall stays 1.
- Reset mid-WAIT (rst low for half a cycle) → all outputs 0 immediately and no done pulse; after release, a new request completes with normal latency.
- MEM_LAT=1 and MEM_LAT=15 sweep, 20 back-to-back fetches → done spacing exactly MEM_LAT+3 cycles; if_grants=20.

Source files
------------

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store.
// Serves one access at a time (data first), waits MEM_LAT cycles, returns data and stalls.
module mem_arbiter #(
  parameter int MEM_LAT = 2,
  parameter int AW      = 16,
  parameter int DW      = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic [DW-1:0] if_rdata_o,
  output logic          if_done_o,
  output logic          if_stall_o,
  input  logic          d_rd_i,
  input  logic          d_wr_i,
  input  logic [AW-1:0] d_addr_i,
  input  logic [DW-1:0] d_wdata_i,
  output logic [DW-1:0] d_rdata_o,
  output logic          d_done_o,
  output logic          d_stall_o,
  input  logic          halt_i,
  output logic          mem_en_o,
  output logic          mem_wr_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  output logic [15:0]   if_grants_o,
  output logic [15:0]   d_grants_o
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, HALTED} state_e;

  localparam logic [3:0] LatCnt = 4'(MEM_LAT);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          ownerData_q, ownerData_d;
  logic          memWr_q, memWr_d;
  logic [AW-1:0] memAddr_q, memAddr_d;
  logic [DW-1:0] memWdata_q, memWdata_d;
  logic [DW-1:0] ifRdata_q, ifRdata_d;
  logic [DW-1:0] dRdata_q, dRdata_d;
  logic [15:0]   ifGrants_q, ifGrants_d;
  logic [15:0]   dGrants_q, dGrants_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ownerData_q <= 1'b0;
      memWr_q     <= 1'b0;
      memAddr_q   <= '0;
      memWdata_q  <= '0;
      ifRdata_q   <= '0;
      dRdata_q    <= '0;
      ifGrants_q  <= '0;
      dGrants_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ownerData_q <= ownerData_d;
      memWr_q     <= memWr_d;
      memAddr_q   <= memAddr_d;
      memWdata_q  <= memWdata_d;
      ifRdata_q   <= ifRdata_d;
      dRdata_q    <= dRdata_d;
      ifGrants_q  <= ifGrants_d;
      dGrants_q   <= dGrants_d;
    end
  end

  // Data wins over fetch: it belongs to the older instruction in the pipeline.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ownerData_d = ownerData_q;
    memWr_d     = memWr_q;
    memAddr_d   = memAddr_q;
    memWdata_d  = memWdata_q;
    ifRdata_d   = ifRdata_q;
    dRdata_d    = dRdata_q;
    ifGrants_d  = ifGrants_q;
    dGrants_d   = dGrants_q;
    unique case (state_q)
      IDLE: begin
        if (halt_i) begin
          state_d = HALTED;
        end else if (d_rd_i || d_wr_i) begin
          ownerData_d = 1'b1;
          memWr_d     = d_wr_i;
          memAddr_d   = d_addr_i;
          memWdata_d  = d_wdata_i;
          state_d     = ISSUE;
        end else if (if_req_i) begin
          ownerData_d = 1'b0;
          memWr_d     = 1'b0;
          memAddr_d   = if_addr_i;
          memWdata_d  = '0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = LatCnt;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          if (!ownerData_q) begin
            ifRdata_d = mem_rdata_i;
          end else if (!memWr_q) begin
            dRdata_d = mem_rdata_i;
          end
          state_d = DONE;
        end
      end
      DONE: begin
        if (ownerData_q) begin
          if (dGrants_q != 16'hFFFF) dGrants_d = dGrants_q + 16'd1;
        end else begin
          if (ifGrants_q != 16'hFFFF) ifGrants_d = ifGrants_q + 16'd1;
        end
        state_d = IDLE;
      end
      HALTED: state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  // The memory bus is driven only during the single ISSUE cycle.
  assign mem_en_o    = (state_q == ISSUE);
  assign mem_wr_o    = mem_en_o & memWr_q;
  assign mem_addr_o  = mem_en_o ? memAddr_q : '0;
  assign mem_wdata_o = mem_en_o ? memWdata_q : '0;

  assign if_done_o   = (state_q == DONE) & ~ownerData_q;
  assign d_done_o    = (state_q == DONE) & ownerData_q;
  assign if_rdata_o  = ifRdata_q;
  assign d_rdata_o   = dRdata_q;
  assign if_stall_o  = if_req_i & ~if_done_o;
  assign d_stall_o   = (d_rd_i | d_wr_i) & ~d_done_o;
  assign if_grants_o = ifGrants_q;
  assign d_grants_o  = dGrants_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: three instances at MEM_LAT 2, 1 and 15,
// each with a fixed-latency memory model that returns data only in its valid cycle.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rstN;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  logic        ifReq[3], dRd[3], dWr[3], halt[3];
  logic [15:0] ifAddr[3], dAddr[3], dWdata[3];
  logic [15:0] ifRdata[3], dRdata[3], memAddr[3], memWdata[3], memRdata[3];
  logic [15:0] ifGrants[3], dGrants[3];
  logic        ifDone[3], ifStall[3], dDone[3], dStall[3], memEn[3], memWr[3];

  typedef struct {
    int          inst;
    bit          isData;
    logic [15:0] rdata;
    int          doneCyc;
  } exp_t;

  exp_t expQ[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int latOf(input int g);
    return (g == 0) ? 2 : ((g == 1) ? 1 : 15);
  endfunction

  function automatic logic [15:0] memFn(input logic [15:0] a);
    case (a)
      16'h0010: return 16'hC123;
      16'h0100: return 16'h1234;
      default:  return a ^ 16'hF0F0;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : gInst
    localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
    logic [15:0] pendAddr = '0;
    int          pendCnt = 0;

    mem_arbiter #(.MEM_LAT(LAT), .AW(16), .DW(16)) dut (
      .clk_i(clk), .rst_ni(rstN),
      .if_req_i(ifReq[g]), .if_addr_i(ifAddr[g]), .if_rdata_o(ifRdata[g]),
      .if_done_o(ifDone[g]), .if_stall_o(ifStall[g]),
      .d_rd_i(dRd[g]), .d_wr_i(dWr[g]), .d_addr_i(dAddr[g]), .d_wdata_i(dWdata[g]),
      .d_rdata_o(dRdata[g]), .d_done_o(dDone[g]), .d_stall_o(dStall[g]),
      .halt_i(halt[g]),
      .mem_en_o(memEn[g]), .mem_wr_o(memWr[g]), .mem_addr_o(memAddr[g]),
      .mem_wdata_o(memWdata[g]), .mem_rdata_i(memRdata[g]),
      .if_grants_o(ifGrants[g]), .d_grants_o(dGrants[g])
    );

    // Read data is valid only in the cycle exactly LAT cycles after the strobe.
    always @(posedge clk) begin
      if (memEn[g]) begin
        pendAddr <= memAddr[g];
        pendCnt  <= LAT;
      end else if (pendCnt > 0) begin
        pendCnt <= pendCnt - 1;
      end
    end
    assign memRdata[g] = (pendCnt == 1) ? memFn(pendAddr) : 16'hDEAD;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic pushExp(input int g, input bit isData, input logic [15:0] rdata, input int doneCyc);
    exp_t e;
    e.inst = g; e.isData = isData; e.rdata = rdata; e.doneCyc = doneCyc;
    expQ.push_back(e);
  endtask

  // Monitor: every completion pulse is matched against the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    for (int g = 0; g < 3; g++) begin
      if (ifDone[g] || dDone[g]) begin
        if (expQ.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_done: inst %0d pulsed done at cycle %0d, expected none", g, cyc);
        end else begin
          e = expQ.pop_front();
          checkOutput("done_inst", 32'(g), 32'(e.inst));
          checkOutput("done_owner", 32'(dDone[g]), 32'(e.isData));
          checkOutput("done_cycle", 32'(cyc), 32'(e.doneCyc));
          checkOutput("done_rdata", 32'(dDone[g] ? dRdata[g] : ifRdata[g]), 32'(e.rdata));
        end
      end
    end
  end

  // kind: 0 fetch, 1 load, 2 store; arbiter must be idle when called.
  task automatic applyStimulus(input int g, input int kind, input logic [15:0] addr,
                               input logic [15:0] wdata, input logic [15:0] expRdata);
    int lat, k, enCount;
    bit seenDone, doneNow, stallNow;
    lat = latOf(g);
    @(posedge clk); #1;
    if (kind == 0) begin ifReq[g] = 1'b1; ifAddr[g] = addr; end
    else if (kind == 1) begin dRd[g] = 1'b1; dAddr[g] = addr; end
    else begin dWr[g] = 1'b1; dAddr[g] = addr; dWdata[g] = wdata; end
    k = cyc;
    pushExp(g, kind != 0, expRdata, k + lat + 2);
    enCount = 0;
    seenDone = 1'b0;
    for (int n = 0; n < lat + 10 && !seenDone; n++) begin
      @(negedge clk);
      if (memEn[g]) begin
        enCount++;
        checkOutput("mem_en_cycle", 32'(cyc), 32'(k + 1));
        checkOutput("mem_wr", 32'(memWr[g]), 32'(kind == 2));
        checkOutput("mem_addr", 32'(memAddr[g]), 32'(addr));
        if (kind == 2) checkOutput("mem_wdata", 32'(memWdata[g]), 32'(wdata));
      end
      doneNow  = (kind == 0) ? ifDone[g] : dDone[g];
      stallNow = (kind == 0) ? ifStall[g] : dStall[g];
      if (doneNow) begin
        seenDone = 1'b1;
        checkOutput("stall_at_done", 32'(stallNow), 32'd0);
      end else begin
        checkOutput("stall_before_done", 32'(stallNow), 32'd1);
      end
    end
    if (!seenDone) checkOutput("done_timeout", 32'd0, 32'd1);
    checkOutput("mem_en_count", 32'(enCount), 32'd1);
    @(posedge clk); #1;
    ifReq[g] = 1'b0; dRd[g] = 1'b0; dWr[g] = 1'b0;
  endtask

  task automatic waitIfDone(input int g, input int budget);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clk);
      if (ifDone[g]) seen = 1'b1;
    end
    if (!seen) checkOutput("fetch_done_timeout", 32'd0, 32'd1);
  endtask

  // Requests stay high; the next address is presented in the IDLE cycle after each done.
  task automatic runSweep(input int g);
    int lat, nextDone;
    lat = latOf(g);
    @(posedge clk); #1;
    ifReq[g] = 1'b1;
    ifAddr[g] = 16'h0000;
    nextDone = cyc + lat + 2;
    pushExp(g, 1'b0, memFn(16'h0000), nextDone);
    for (int i = 0; i < 20; i++) begin
      waitIfDone(g, lat + 10);
      @(posedge clk); #1;
      if (i < 19) begin
        ifAddr[g] = 16'(i + 1);
        nextDone += lat + 3;
        pushExp(g, 1'b0, memFn(16'(i + 1)), nextDone);
      end else begin
        ifReq[g] = 1'b0;
      end
    end
    @(negedge clk);
    checkOutput("sweep_if_grants", 32'(ifGrants[g]), 32'd20);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected to finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k, enCount;
    bit seen;
    rstN = 1'b0;
    for (int g = 0; g < 3; g++) begin
      ifReq[g] = 1'b0; dRd[g] = 1'b0; dWr[g] = 1'b0; halt[g] = 1'b0;
      ifAddr[g] = '0; dAddr[g] = '0; dWdata[g] = '0;
    end
    #3;
    checkOutput("reset_mem_en", 32'(memEn[0]), 32'd0);
    checkOutput("reset_if_done", 32'(ifDone[0]), 32'd0);
    checkOutput("reset_d_done", 32'(dDone[0]), 32'd0);
    checkOutput("reset_if_rdata", 32'(ifRdata[0]), 32'd0);
    checkOutput("reset_if_grants", 32'(ifGrants[0]), 32'd0);
    checkOutput("reset_d_grants", 32'(dGrants[0]), 32'd0);
    repeat (2) @(negedge clk);
    #1 rstN = 1'b1;

    $display("[TB] single fetch");
    applyStimulus(0, 0, 16'h0010, 16'h0000, 16'hC123);
    @(negedge clk);
    checkOutput("if_grants_after_fetch", 32'(ifGrants[0]), 32'd1);

    $display("[TB] simultaneous fetch and load");
    @(posedge clk); #1;
    ifReq[0] = 1'b1; ifAddr[0] = 16'h0000;
    dRd[0] = 1'b1;   dAddr[0] = 16'h0100;
    k = cyc;
    pushExp(0, 1'b1, 16'h1234, k + 4);
    pushExp(0, 1'b0, 16'hF0F0, k + 9);
    enCount = 0;
    seen = 1'b0;
    for (int n = 0; n < 30 && !seen; n++) begin
      @(negedge clk);
      if (memEn[0]) enCount++;
      if (ifDone[0]) seen = 1'b1;
      else checkOutput("if_stall_through_both", 32'(ifStall[0]), 32'd1);
      if (dDone[0]) begin
        #6 dRd[0] = 1'b0;
      end
    end
    if (!seen) checkOutput("simul_timeout", 32'd0, 32'd1);
    checkOutput("simul_mem_en_count", 32'(enCount), 32'd2);
    @(posedge clk); #1 ifReq[0] = 1'b0;

    $display("[TB] store");
    applyStimulus(0, 2, 16'h0200, 16'hBEEF, 16'h1234);
    @(negedge clk);
    checkOutput("if_grants_pre_reset", 32'(ifGrants[0]), 32'd2);
    checkOutput("d_grants_pre_reset", 32'(dGrants[0]), 32'd2);

    $display("[TB] reset during WAIT");
    @(posedge clk); #1;
    ifReq[0] = 1'b1; ifAddr[0] = 16'h0040;
    repeat (3) @(negedge clk);
    #1;
    rstN = 1'b0;
    ifReq[0] = 1'b0;
    #1;
    checkOutput("midreset_if_done", 32'(ifDone[0]), 32'd0);
    checkOutput("midreset_if_rdata", 32'(ifRdata[0]), 32'd0);
    checkOutput("midreset_d_rdata", 32'(dRdata[0]), 32'd0);
    checkOutput("midreset_if_grants", 32'(ifGrants[0]), 32'd0);
    checkOutput("midreset_d_grants", 32'(dGrants[0]), 32'd0);
    #2 rstN = 1'b1;
    repeat (4) @(negedge clk);
    applyStimulus(0, 0, 16'h0050, 16'h0000, 16'hF0A0);
    @(negedge clk);
    checkOutput("if_grants_post_reset", 32'(ifGrants[0]), 32'd1);

    $display("[TB] halt during WAIT");
    fork
      applyStimulus(0, 0, 16'h0020, 16'h0000, 16'hF0D0);
      begin
        @(posedge clk); #1;
        repeat (2) @(posedge clk);
        #1 halt[0] = 1'b1;
      end
    join
    @(negedge clk);
    checkOutput("if_grants_after_halt", 32'(ifGrants[0]), 32'd2);
    @(posedge clk); #1;
    ifReq[0] = 1'b1; ifAddr[0] = 16'h0030;
    dRd[0] = 1'b1;   dAddr[0] = 16'h0300;
    enCount = 0;
    repeat (20) begin
      @(negedge clk);
      if (memEn[0]) enCount++;
    end
    checkOutput("halted_mem_en_count", 32'(enCount), 32'd0);
    checkOutput("halted_if_stall", 32'(ifStall[0]), 32'd1);
    checkOutput("halted_d_stall", 32'(dStall[0]), 32'd1);
    checkOutput("halted_if_grants", 32'(ifGrants[0]), 32'd2);

    $display("[TB] back-to-back sweep MEM_LAT=1");
    runSweep(1);
    $display("[TB] back-to-back sweep MEM_LAT=15");
    runSweep(2);

    repeat (5) @(negedge clk);
    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
